// File: rtl/gate_mux_identifier.sv
// Gate identifier: sweeps the four {s,b} input vectors into a 2-input gate, samples its
// output, builds the truth table and decodes it to a function code. Multiple passes
// must agree, otherwise the result is flagged unstable.
module gate_mux_identifier #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PASSES        = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       obs_y,
    output logic       drv_s,
    output logic       drv_b,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth,
    output logic [2:0] func_code,
    output logic       valid_match,
    output logic       unstable
);

    localparam int unsigned CntW  = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int unsigned PassW = (PASSES > 1) ? $clog2(PASSES) : 1;
    // Only meaningful when SETTLE_CYCLES > 0; StDrive is never entered otherwise.
    localparam logic [CntW-1:0]  CntLast  = CntW'(SETTLE_CYCLES - 1);
    localparam logic [PassW-1:0] PassLast = PassW'(PASSES - 1);
    localparam bit               NoSettle = (SETTLE_CYCLES == 0);

    typedef enum logic [1:0] {StIdle, StDrive, StSample, StDecide} state_e;

    state_e           state_q;
    logic [1:0]       idx_q;
    logic [1:0]       idx_next;
    logic [PassW-1:0] pass_q;
    logic [CntW-1:0]  cnt_q;
    logic [3:0]       tt_q;     // table captured in pass 1, published at decide
    logic             mism_q;   // later pass disagreed with pass 1
    logic [2:0]       code_d;
    logic             valid_d;

    assign idx_next = idx_q + 2'd1;

    // Decode the captured table; any disagreement between passes forces UNKNOWN.
    always_comb begin
        code_d = 3'd7;
        case (tt_q)
            4'b1000: code_d = 3'd0;
            4'b1110: code_d = 3'd1;
            4'b1100: code_d = 3'd2;
            4'b0111: code_d = 3'd3;
            4'b0001: code_d = 3'd4;
            4'b0110: code_d = 3'd5;
            4'b1001: code_d = 3'd6;
            default: code_d = 3'd7;
        endcase
        if (mism_q) begin
            code_d = 3'd7;
        end
        valid_d = (code_d != 3'd7);
    end

    // Sweep FSM with registered stimulus and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= 2'd0;
            pass_q      <= '0;
            cnt_q       <= '0;
            tt_q        <= 4'd0;
            mism_q      <= 1'b0;
            drv_s       <= 1'b0;
            drv_b       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth       <= 4'd0;
            func_code   <= 3'd7;
            valid_match <= 1'b0;
            unstable    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    drv_s <= 1'b0;
                    drv_b <= 1'b0;
                    if (start) begin
                        busy     <= 1'b1;
                        idx_q    <= 2'd0;
                        pass_q   <= '0;
                        cnt_q    <= '0;
                        mism_q   <= 1'b0;
                        unstable <= 1'b0;
                        state_q  <= NoSettle ? StSample : StDrive;
                    end
                end
                StDrive: begin
                    if (cnt_q == CntLast) begin
                        state_q <= StSample;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StSample: begin
                    if (pass_q == '0) begin
                        tt_q[idx_q] <= obs_y;
                    end else if (obs_y != tt_q[idx_q]) begin
                        mism_q <= 1'b1;
                    end
                    cnt_q <= '0;
                    if (idx_q == 2'd3 && pass_q == PassLast) begin
                        state_q <= StDecide;
                    end else begin
                        idx_q <= idx_next;
                        if (idx_q == 2'd3) begin
                            pass_q <= pass_q + 1'b1;
                        end
                        drv_s   <= idx_next[1];
                        drv_b   <= idx_next[0];
                        state_q <= NoSettle ? StSample : StDrive;
                    end
                end
                StDecide: begin
                    truth       <= tt_q;
                    func_code   <= code_d;
                    valid_match <= valid_d;
                    unstable    <= mism_q;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    drv_s       <= 1'b0;
                    drv_b       <= 1'b0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
